// File: rtl/tp_pkg.sv
// Shared definitions for the CPU test-port result protocol: default port address,
// frame symbols, writer state encoding and the little-endian byte swap.
package tp_pkg;

  localparam logic [29:0] TEST_PORT_DEF = 30'h0000_0010;
  localparam logic [31:0] BEGIN_SYM_DEF = 32'h0000_0168;
  localparam logic [31:0] END_SYM_DEF   = 32'hFFFF_FD5D;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BEGIN = 3'd1,
    ST_GAP      = 3'd2,
    ST_FETCH    = 3'd3,
    ST_WR_WORD  = 3'd4,
    ST_WR_END   = 3'd5,
    ST_DONE     = 3'd6
  } tp_state_e;

  function automatic logic [31:0] le_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/test_port_writer.sv
// Test-port frame transmitter: BEGIN, NUM_WORDS payload words from a valid/ready
// stream, then END, each written little-endian to TEST_PORT with programmable timing.
module test_port_writer
  import tp_pkg::*;
#(
  parameter logic [29:0] TEST_PORT = TEST_PORT_DEF,
  parameter logic [31:0] BEGIN_SYM = BEGIN_SYM_DEF,
  parameter logic [31:0] END_SYM   = END_SYM_DEF,
  parameter int unsigned NUM_WORDS = 18,
  parameter int unsigned WEN_HOLD  = 1,
  parameter int unsigned GAP       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [29:0] addr,
  output logic [31:0] data,
  output logic        wen,
  output logic        busy,
  output logic        done,
  output logic [4:0]  sent_cnt
);

  localparam logic [7:0] HOLD_LAST = 8'(WEN_HOLD - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);
  localparam logic [4:0] WORDS     = 5'(NUM_WORDS);

  tp_state_e   state_r, state_s;
  logic [7:0]  hold_cnt_r, hold_cnt_s;
  logic [7:0]  gap_cnt_r, gap_cnt_s;
  logic        last_end_r, last_end_s;
  logic [29:0] addr_r, addr_s;
  logic [31:0] data_r, data_s;
  logic        wen_r, wen_s;
  logic        in_ready_r, in_ready_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [4:0]  sent_cnt_r, sent_cnt_s;

  // Next-state decode; outputs are derived from the state being entered so they can be registered.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    last_end_s = last_end_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s    = ST_WR_BEGIN;
          hold_cnt_s = 8'd0;
          last_end_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_WR_BEGIN, ST_WR_WORD, ST_WR_END: begin
        // A stalled cycle never counts toward the hold, even on the final one.
        if (stall) begin
          hold_cnt_s = hold_cnt_r;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s    = ST_GAP;
          gap_cnt_s  = 8'd0;
          last_end_s = (state_r == ST_WR_END);
        end else begin
          hold_cnt_s = hold_cnt_r + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r != GAP_LAST) begin
          gap_cnt_s = gap_cnt_r + 8'd1;
        end else if (last_end_r) begin
          state_s = ST_DONE;
        end else if (sent_cnt_r == WORDS) begin
          state_s    = ST_WR_END;
          hold_cnt_s = 8'd0;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (in_valid && in_ready_r) begin
          state_s    = ST_WR_WORD;
          hold_cnt_s = 8'd0;
        end else begin
          state_s = ST_FETCH;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    wen_s      = (state_s == ST_WR_BEGIN) || (state_s == ST_WR_WORD) || (state_s == ST_WR_END);
    addr_s     = wen_s ? TEST_PORT : 30'h0;
    in_ready_s = (state_s == ST_FETCH);
    busy_s     = (state_s != ST_IDLE) && (state_s != ST_DONE);
    done_s     = (state_s == ST_DONE);

    // The payload word is captured straight into the data register on acceptance.
    case (state_s)
      ST_WR_BEGIN: data_s = le_swap32(BEGIN_SYM);
      ST_WR_WORD:  data_s = (state_r == ST_FETCH) ? le_swap32(in_data) : data_r;
      ST_WR_END:   data_s = le_swap32(END_SYM);
      default:     data_s = 32'h0;
    endcase

    if (state_s == ST_WR_BEGIN) begin
      sent_cnt_s = 5'd0;
    end else if ((state_r == ST_FETCH) && (state_s == ST_WR_WORD)) begin
      sent_cnt_s = sent_cnt_r + 5'd1;
    end else begin
      sent_cnt_s = sent_cnt_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= 8'd0;
      gap_cnt_r  <= 8'd0;
      last_end_r <= 1'b0;
      addr_r     <= 30'h0;
      data_r     <= 32'h0;
      wen_r      <= 1'b0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sent_cnt_r <= 5'd0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      last_end_r <= last_end_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      wen_r      <= wen_s;
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      sent_cnt_r <= sent_cnt_s;
    end
  end

  assign addr     = addr_r;
  assign data     = data_r;
  assign wen      = wen_r;
  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign sent_cnt = sent_cnt_r;

endmodule

// File: doc/test_port_writer.md
Name: test_port_writer

Overview:
- Transmitter side of the CPU test-port result protocol. It drives the memory-write signals (addr, data, wen) that the testbench result checker consumes.
- Frame format: BEGIN symbol, then NUM_WORDS payload words taken from a valid/ready input stream, then END symbol.
- Every word is written to TEST_PORT, byte-swapped to little-endian.
- Used to self-test the checker and to stand in for the CPU/D-cache write path in block-level benches. Supports configurable wen hold length and a stall input that emulates D-cache stalls.

Parameters:
- TEST_PORT, 30'h10, word address of the test port.
- BEGIN_SYM, 32'h00000168, frame start symbol in readable (big-endian) form.
- END_SYM, 32'hFFFFFD5D, frame end symbol in readable form.
- NUM_WORDS, 18, payload words per frame (1..31).
- WEN_HOLD, 1, minimum cycles wen stays high per write (1..255).
- GAP, 1, cycles wen stays low between writes (1..255; 0 is illegal, because the checker needs a wen low edge per word).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled in IDLE or DONE
- stall  in  1  extends the current write while high (emulated D-cache stall)
- in_valid  in  1  payload word available
- in_data  in  32  payload word, readable form
- in_ready  out  1  writer accepts in_data this cycle
- addr  out  30  write word address
- data  out  32  write data, little-endian byte order
- wen  out  1  write enable
- busy  out  1  frame in progress
- done  out  1  frame complete; level signal
- sent_cnt  out  5  payload words written so far in the current frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst. All outputs are registered.
- Reset values: addr=0, data=0, wen=0, in_ready=0, busy=0, done=0, sent_cnt=0; state=IDLE.
- An rst assertion mid-frame aborts the frame. wen is low from the next edge, and no END is written.
- Byte swap: data = {w[7:0], w[15:8], w[23:16], w[31:24]}.
- While wen=0, addr and data are driven to 0.
- FSM states: IDLE, WR_BEGIN, GAP, FETCH, WR_WORD, WR_END, DONE.
- IDLE:
  - start=1 -> WR_BEGIN.
  - On the next cycle: wen=1, addr=TEST_PORT, data=swap(BEGIN_SYM), busy=1.
- WR_* states (shared write timing):
  - The hold counter counts cycles with stall=0.
  - wen stays high until WEN_HOLD non-stalled cycles have elapsed, then the FSM moves to GAP.
  - Stall cycles add to the wen-high length and never shorten it.
  - addr and data are stable for the whole wen-high interval.
- GAP:
  - wen=0 for exactly GAP cycles. The GAP count is independent of stall.
  - Then: if the previous write was WR_END -> DONE. Otherwise, if sent_cnt==NUM_WORDS -> WR_END. Otherwise -> FETCH.
- FETCH:
  - in_ready=1 for as long as the FSM is in FETCH.
  - On in_valid&&in_ready, capture in_data and go to WR_WORD. The write starts the next cycle.
  - With no in_valid, the FSM waits indefinitely with wen=0.
  - in_ready=0 in every other state.
- WR_WORD: sent_cnt increments on the first wen-high cycle.
- WR_END: data=swap(END_SYM).
- DONE:
  - done=1, busy=0, wen=0; sent_cnt holds its final value.
  - start=1 -> clear done and sent_cnt, then go to WR_BEGIN.
  - start=1 is ignored in every state except IDLE and DONE.
- Minimum latency: start -> first wen is 1 cycle. One word occupies WEN_HOLD+GAP cycles, plus 1 FETCH cycle per payload word.
- Defaults, back-to-back input: the frame is 1 (start) + 2 (BEGIN) + 18×3 (payload) + 2 (END) = 59 cycles to DONE. The +1 per payload word is the FETCH cycle.
- Simultaneous stall and hold-counter expiry: stall wins, and the write extends.
- Widths: hold and gap counters are 8 bits; sent_cnt is 5 bits and never wraps, because NUM_WORDS ≤ 31.

Decomposition:
- Shared package tp_pkg: TEST_PORT, BEGIN_SYM, END_SYM default constants; the state enum; the byte-swap function le_swap32.
- Both the checker and this writer import tp_pkg.
- No sub-module. The hold and gap counters are small enough to stay inline.

Test Plan:
- Default frame, in_valid always high, payload 0x00001234, 0x0000ABCD, 0x091A0000 … 0x0C374FA4 -> bus shows 0x68010000, 0x34120000, 0xCDAB0000, … , 0x5DFDFFFF at addr 0x10. The checker reports 0 errors; done at cycle 59.
- WEN_HOLD=3, stall high for 4 cycles during payload word 5 -> that write has wen high for 7 cycles, data stable throughout, and exactly one checker count.
- in_valid deasserted for 10 cycles before word 3 -> in_ready=1 and wen=0 for those 10 cycles; the word is written once, the cycle after in_valid rises.
- rst asserted during word 7 -> next cycle wen=0, busy=0, sent_cnt=0, and no END appears. A following start sends a complete frame beginning with 0x68010000.
- start pulsed while busy -> ignored. start in DONE -> done clears next cycle, and the second frame is identical to the first.
- GAP=4 -> every wen-low interval between writes is exactly 4 cycles, measured across the whole frame.
